// File: rtl/event_group_scheduler.sv
// event_group_scheduler: group-locked round-robin pixel request scheduler.
// 16 requests form 4 groups of 4 members. A group is locked and its members
// are granted lowest-index first, each at most once per lock; the group is
// then released and the search continues from the following group.
// Optional HOLD timeout is enabled by defining SCHED_TIMEOUT_EN.
module event_group_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic [15:0] req_i,
    input  logic        ack_i,
    output logic [15:0] gnt_o,
    output logic        valid_o,
    output logic [3:0]  addr_o,
    output logic        grp_release_o,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grp_ptr_q, grp_ptr_d;
    logic [1:0]  cur_grp_q, cur_grp_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] gnt_d;
    logic [3:0]  addr_d;
    logic        valid_d;
    logic        rel_pulse;
    logic        to_pulse;

    logic [1:0]  first_grp;
    logic [1:0]  scan_grp;
    logic [3:0]  mreq;
    logic [1:0]  mem;

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          tcnt_hit;
    assign tcnt_hit = (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    // The parameter only matters in the timeout build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    // Round-robin search for the first requesting group starting at grp_ptr;
    // scanning backwards lets the closest group overwrite the others.
    always_comb begin
        first_grp = grp_ptr_q;
        scan_grp  = '0;
        for (int unsigned k = 4; k > 0; k--) begin
            scan_grp = grp_ptr_q + 2'(k - 1);
            if (|req_i[{scan_grp, 2'b00} +: 4]) begin
                first_grp = scan_grp;
            end
        end
    end

    // Lowest-index member of the locked group still allowed by the mask.
    always_comb begin
        mreq = req_i[{cur_grp_q, 2'b00} +: 4] & mask_q;
        mem  = '0;
        for (int unsigned k = 4; k > 0; k--) begin
            if (mreq[k-1]) begin
                mem = 2'(k - 1);
            end
        end
    end

    // Next-state, next-output and pulse logic of the IDLE/SEL/HOLD machine.
    always_comb begin
        state_d   = state_q;
        grp_ptr_d = grp_ptr_q;
        cur_grp_d = cur_grp_q;
        mask_d    = mask_q;
        gnt_d     = gnt_o;
        addr_d    = addr_o;
        valid_d   = valid_o;
        rel_pulse = 1'b0;
        to_pulse  = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        tcnt_d    = tcnt_q;
`endif
        if (enable_i) begin
            unique case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        cur_grp_d = first_grp;
                        mask_d    = '1;
                        state_d   = SEL;
                    end
                end
                SEL: begin
                    if (|mreq) begin
                        valid_d = 1'b1;
                        addr_d  = {cur_grp_q, mem};
                        gnt_d   = 16'd1 << {cur_grp_q, mem};
                        mask_d  = 4'b1110 << mem;
                        state_d = HOLD;
`ifdef SCHED_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end else begin
                        rel_pulse = 1'b1;
                        grp_ptr_d = cur_grp_q + 2'd1;
                        mask_d    = '1;
                        state_d   = IDLE;
                    end
                end
                HOLD: begin
                    if (ack_i) begin
                        valid_d = 1'b0;
                        gnt_d   = '0;
                        addr_d  = '0;
                        state_d = SEL;
`ifdef SCHED_TIMEOUT_EN
                    end else if (tcnt_hit) begin
                        valid_d  = 1'b0;
                        gnt_d    = '0;
                        addr_d   = '0;
                        to_pulse = 1'b1;
                        state_d  = SEL;
                    end else begin
                        tcnt_d = tcnt_q + CW'(1);
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grp_ptr_q <= '0;
            cur_grp_q <= '0;
            mask_q    <= '1;
            gnt_o     <= '0;
            addr_o    <= '0;
            valid_o   <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            tcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grp_ptr_q <= grp_ptr_d;
            cur_grp_q <= cur_grp_d;
            mask_q    <= mask_d;
            gnt_o     <= gnt_d;
            addr_o    <= addr_d;
            valid_o   <= valid_d;
`ifdef SCHED_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
`endif
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign grp_release_o = rel_pulse & ~reset;
    assign timeout_o     = to_pulse & ~reset;

endmodule

// File: tb/tb_event_group_scheduler.sv
// Self-checking bench for event_group_scheduler: directed scenarios plus
// randomized traffic, all compared against a behavioural reference model.
module tb_event_group_scheduler;

    localparam int unsigned T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_i = 1'b1;
    logic        ack_i = 1'b0;
    logic [15:0] req_i = '0;
    logic [15:0] gnt_o;
    logic        valid_o;
    logic [3:0]  addr_o;
    logic        grp_release_o;
    logic        busy_o;
    logic        timeout_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    event_group_scheduler #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i), .req_i(req_i),
        .ack_i(ack_i), .gnt_o(gnt_o), .valid_o(valid_o), .addr_o(addr_o),
        .grp_release_o(grp_release_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    // Reference model: phase 0 idle, 1 choosing a member, 2 holding a grant.
    // last_m is the highest member already served in the locked group.
    int ph = 0, mptr = 0, mgrp = 0, last_m = -1, maddr = 0, mcnt = 0;
    logic [23:0] e_vec;

    function automatic logic [23:0] obs();
        return {valid_o, busy_o, grp_release_o, timeout_o, addr_o, gnt_o};
    endfunction

    function automatic int next_member();
        for (int m = last_m + 1; m < 4; m++)
            if (req_i[mgrp*4 + m]) return m;
        return -1;
    endfunction

    function automatic int first_group();
        for (int k = 0; k < 4; k++) begin
            int g = (mptr + k) % 4;
            if (((req_i >> (4*g)) & 16'hF) != 0) return g;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int g, nm;
        if (reset) begin
            ph = 0; mptr = 0; mgrp = 0; last_m = -1; mcnt = 0;
        end else if (enable_i) begin
            case (ph)
                0: begin
                    g = first_group();
                    if (g >= 0) begin mgrp = g; last_m = -1; ph = 1; end
                end
                1: begin
                    nm = next_member();
                    if (nm >= 0) begin
                        maddr = mgrp*4 + nm; last_m = nm; ph = 2; mcnt = 0;
                    end else begin
                        mptr = (mgrp + 1) % 4; last_m = -1; ph = 0;
                    end
                end
                default: begin
                    if (ack_i) ph = 1;
`ifdef SCHED_TIMEOUT_EN
                    else if (mcnt == T - 1) ph = 1;
                    else mcnt++;
`endif
                end
            endcase
        end
    endtask

    task automatic model_expect();
        logic v, b, r, t;
        logic [3:0] a;
        logic [15:0] gv;
        v  = (ph == 2);
        b  = (ph != 0);
        a  = v ? 4'(maddr) : 4'h0;
        gv = v ? (16'd1 << maddr) : 16'h0;
        r  = !reset && enable_i && ph == 1 && next_member() < 0;
        t  = 1'b0;
`ifdef SCHED_TIMEOUT_EN
        t  = !reset && enable_i && ph == 2 && !ack_i && mcnt == T - 1;
`endif
        e_vec = {v, b, r, t, a, gv};
    endtask

    // Advance one clock: model follows the edge, then new inputs are applied.
    task automatic cyc(input logic [15:0] r, input logic a, input logic e, input logic rs);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        req_i = r; ack_i = a; enable_i = e; reset = rs;
        #1;
        model_expect();
    endtask

    task automatic do_reset();
        cyc(16'h0, 1'b0, 1'b1, 1'b1);
        cyc(16'h0, 1'b0, 1'b1, 1'b0);
    endtask

    // Run with ack low until a grant shows up, at most 10 cycles.
    task automatic wait_grant(input logic [15:0] r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++)
            if (!ok) begin
                cyc(r, 1'b0, 1'b1, 1'b0);
                ok = valid_o;
            end
    endtask

    task automatic test_reset();
        cyc(16'hFFFF, 1'b1, 1'b1, 1'b1);
        cyc(16'hFFFF, 1'b1, 1'b1, 1'b1);
        cyc(16'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs() !== 24'h0) begin
            failures++; $display("FAIL reset_outputs got %h want 000000", obs());
        end
        checks++;
        if (obs() !== e_vec) begin
            failures++; $display("FAIL reset_model got %h want %h", obs(), e_vec);
        end
    endtask

    task automatic test_two_members();
        int seq[$];
        int rel = 0;
        bit prev = 1'b0, ok;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(seq.size() < 2 ? 16'h0005 : 16'h0000, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs() !== e_vec) begin
                failures++; $display("FAIL two_members_model cyc %0d got %h want %h", i, obs(), e_vec);
            end
            if (valid_o && !prev) seq.push_back(int'(addr_o));
            if (grp_release_o) rel++;
            prev = valid_o;
        end
        checks++;
        if (seq.size() != 2 || seq[0] != 0 || seq[1] != 2) begin
            failures++; $display("FAIL two_members_seq got n=%0d first=%0d want n=2 addrs 0,2",
                                 seq.size(), seq.size() > 0 ? seq[0] : -1);
        end
        checks++;
        if (rel != 1 || busy_o !== 1'b0) begin
            failures++; $display("FAIL two_members_release got rel=%0d busy=%b want 1,0", rel, busy_o);
        end
        wait_grant(16'h1111, ok);
        checks++;
        if (!ok || addr_o !== 4'h4) begin
            failures++; $display("FAIL two_members_ptr got ok=%0d addr=%h want 1,4", ok, addr_o);
        end
    endtask

    task automatic test_alternate();
        int g[$], ra[$];
        int rel = 0;
        bit prev = 1'b0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cyc(16'h1010, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs() !== e_vec) begin
                failures++; $display("FAIL alternate_model cyc %0d got %h want %h", i, obs(), e_vec);
            end
            if (grp_release_o) rel++;
            if (valid_o && !prev) begin g.push_back(int'(addr_o)); ra.push_back(rel); end
            prev = valid_o;
        end
        checks++;
        if (g.size() < 4 || g[0] != 4) begin
            failures++; $display("FAIL alternate_first got n=%0d first=%0d want n>=4 first=4",
                                 g.size(), g.size() > 0 ? g[0] : -1);
        end
        for (int i = 1; i < g.size(); i++) begin
            checks++;
            if (g[i] != (g[i-1] == 4 ? 12 : 4) || ra[i] <= ra[i-1]) begin
                failures++; $display("FAIL alternate_seq idx %0d got addr=%0d rel=%0d want addr=%0d rel>%0d",
                                     i, g[i], ra[i], g[i-1] == 4 ? 12 : 4, ra[i-1]);
            end
        end
    endtask

    task automatic test_relock();
        int g[$], ra[$];
        int rel = 0;
        bit prev = 1'b1, ok;
        do_reset();
        wait_grant(16'h0004, ok);
        checks++;
        if (!ok || addr_o !== 4'h2) begin
            failures++; $display("FAIL relock_first got ok=%0d addr=%h want 1,2", ok, addr_o);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(16'h0006, 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs() !== e_vec) begin
                failures++; $display("FAIL relock_model cyc %0d got %h want %h", i, obs(), e_vec);
            end
            if (grp_release_o) rel++;
            if (valid_o && !prev) begin g.push_back(int'(addr_o)); ra.push_back(rel); end
            prev = valid_o;
        end
        checks++;
        if (g.size() < 2 || g[0] != 1 || ra[0] < 1 || g[1] != 2) begin
            failures++; $display("FAIL relock_order got n=%0d first=%0d rel=%0d want first=1 after release then 2",
                                 g.size(), g.size() > 0 ? g[0] : -1, ra.size() > 0 ? ra[0] : -1);
        end
    endtask

    task automatic test_hold_stable();
        int held = 0, tos = 0, want_held, want_tos;
        bit ok;
        do_reset();
        wait_grant(16'h0100, ok);
        checks++;
        if (!ok || addr_o !== 4'h8 || gnt_o !== 16'h0100) begin
            failures++; $display("FAIL hold_grant got ok=%0d addr=%h gnt=%h want 1,8,0100", ok, addr_o, gnt_o);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(16'h0000, 1'b0, 1'b1, 1'b0);
            checks++;
            if (obs() !== e_vec) begin
                failures++; $display("FAIL hold_model cyc %0d got %h want %h", i, obs(), e_vec);
            end
            if (valid_o && addr_o == 4'h8 && gnt_o == 16'h0100) held++;
            if (timeout_o) tos++;
        end
`ifdef SCHED_TIMEOUT_EN
        want_held = T - 1; want_tos = 1;
`else
        want_held = 20; want_tos = 0;
`endif
        checks++;
        if (held != want_held || tos != want_tos) begin
            failures++; $display("FAIL hold_stable got held=%0d timeouts=%0d want %0d,%0d",
                                 held, tos, want_held, want_tos);
        end
    endtask

    task automatic test_enable_freeze();
        int frozen = 0;
        bit ok;
        do_reset();
        wait_grant(16'h0001, ok);
        for (int i = 0; i < 5; i++) begin
            cyc(16'h0001, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs() !== e_vec) begin
                failures++; $display("FAIL freeze_model cyc %0d got %h want %h", i, obs(), e_vec);
            end
            if (valid_o && addr_o == 4'h0 && gnt_o == 16'h0001 && !grp_release_o) frozen++;
        end
        cyc(16'h0001, 1'b1, 1'b1, 1'b0);
        checks++;
        if (!ok || frozen != 5 || valid_o !== 1'b1) begin
            failures++; $display("FAIL freeze_hold got ok=%0d frozen=%0d valid=%b want 1,5,1", ok, frozen, valid_o);
        end
        cyc(16'h0000, 1'b0, 1'b1, 1'b0);
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b1 || gnt_o !== 16'h0) begin
            failures++; $display("FAIL freeze_ack got valid=%b busy=%b gnt=%h want 0,1,0000", valid_o, busy_o, gnt_o);
        end
    endtask

    task automatic test_reset_mid_hold();
        bit ok;
        do_reset();
        wait_grant(16'h8000, ok);
        checks++;
        if (!ok || addr_o !== 4'hF) begin
            failures++; $display("FAIL midreset_grant got ok=%0d addr=%h want 1,f", ok, addr_o);
        end
        cyc(16'h8000, 1'b0, 1'b1, 1'b1);
        cyc(16'h1111, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs() !== 24'h0) begin
            failures++; $display("FAIL midreset_clear got %h want 000000", obs());
        end
        wait_grant(16'h1111, ok);
        checks++;
        if (!ok || addr_o !== 4'h0) begin
            failures++; $display("FAIL midreset_restart got ok=%0d addr=%h want 1,0", ok, addr_o);
        end
    endtask

    task automatic test_random();
        logic [15:0] r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 7) == 0) r = '0;
            cyc(r, $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0);
            checks++;
            if (obs() !== e_vec) begin
                failures++; $display("FAIL random_model cyc %0d got %h want %h", i, obs(), e_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_members();
        test_alternate();
        test_relock();
        test_hold_stable();
        test_enable_freeze();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/event_group_scheduler.md
EVENT_GROUP_SCHEDULER -- requirements
Module: event_group_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: the number of HOLD cycles without ack_i before the grant is abandoned. It is used only with SCHED_TIMEOUT_EN.
REQ-002 The design uses one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable_i  in  1  while low, all state is frozen and ack_i is ignored.
REQ-006 req_i  in  16  pixel requests: group g = bits [4g+3:4g], member m = bit 4g+m.
REQ-007 ack_i  in  1  downstream accepts the current grant.
REQ-008 gnt_o  out  16  registered one-hot grant; zero when valid_o=0.
REQ-009 valid_o  out  1  grant/address valid.
REQ-010 addr_o  out  4  registered {group[1:0], member[1:0]} of the grant; zero when valid_o=0.
REQ-011 grp_release_o  out  1  one-cycle pulse when the locked group is released.
REQ-012 busy_o  out  1  high whenever the FSM state is not IDLE.
REQ-013 timeout_o  out  1  one-cycle pulse when a grant is abandoned (SCHED_TIMEOUT_EN only).

Function
REQ-014 The FSM states are IDLE, SEL and HOLD; state plus grp_ptr[1:0], cur_grp[1:0] and mask_q[3:0] are registered.
REQ-015 IDLE, when any req_i bit is set:
- select the first group g with a nonzero request, searching cur order grp_ptr, grp_ptr+1, ... (wrapping mod 4);
- load cur_grp<=g and mask_q<=4'b1111;
- go to SEL.
REQ-016 IDLE with no request: remain in IDLE with all outputs zero.
REQ-017 SEL: let mreq = req_i[cur_grp] & mask_q.
- If mreq is nonzero, grant the lowest-index set member m, drive gnt_o, addr_o and valid_o=1 from the next cycle, and go to HOLD.
- On that grant, mask_q becomes 1110/1100/1000/0000 for m=0/1/2/3.
REQ-018 SEL with mreq zero (group release):
- grp_release_o pulses in this cycle;
- grp_ptr<=cur_grp+1 (mod 4, 3 wraps to 0);
- mask_q<=4'b1111;
- go to IDLE.
REQ-019 HOLD: gnt_o, addr_o and valid_o=1 are held stable until ack_i=1, independent of any req_i changes.
REQ-020 HOLD with ack_i=1: valid_o, gnt_o and addr_o clear on the next edge and the FSM returns to SEL.
REQ-021 ack_i in IDLE or SEL has no effect.
REQ-022 Latency: a request arriving in IDLE at cycle 0 gives valid_o=1 at cycle 2. After an ack at cycle n, the next grant in the same group has valid_o=1 at cycle n+2.
REQ-023 A group stays locked until no masked member remains, so each member is granted at most once per lock. A member requesting again below the mask waits for the next lock of that group.
REQ-024 Groups with no requests are skipped in one IDLE cycle; there is no cycle per empty group.
REQ-025 enable_i=0 holds state, outputs, mask_q and the timeout counter unchanged, and suppresses grp_release_o and timeout_o pulses.

Reset
REQ-026 On reset:
- state=IDLE;
- grp_ptr=0, cur_grp=0, mask_q=4'b1111;
- gnt_o=0, addr_o=0, valid_o=0, grp_release_o=0, busy_o=0, timeout_o=0;
- timeout counter=0.
REQ-027 Reset overrides enable_i and ack_i. Reset asserted during HOLD drops the grant with no ack required and no timeout_o.

Configuration
REQ-028 The macro SCHED_TIMEOUT_EN controls the HOLD timeout.
- Defined: a counter clears on entry to HOLD and increments each enabled HOLD cycle. If it reaches TIMEOUT_CYCLES with ack_i=0, the grant is cleared, timeout_o pulses for one cycle, and the FSM goes to SEL with mask_q already advanced. An ack_i in that same cycle takes priority and gives no timeout.
- Not defined: no counter exists, timeout_o is constant 0, and HOLD waits indefinitely.

Verification
REQ-029 Scenario: reset, then req_i=16'h0005, ack_i=1 each valid cycle -> addr_o 0x0 then 0x2, then grp_release_o pulse, grp_ptr=1, IDLE.
REQ-030 Scenario: req_i=16'h1010 held, ack each grant -> grants alternate group1 (addr 0x4) and group3 (addr 0xC), with grp_release_o between them.
REQ-031 Scenario: group 0 locked, member 2 granted, member 1 re-requests -> member 1 is not granted until after release and relock of group 0.
REQ-032 Scenario: grant in HOLD, ack_i=0 for 20 cycles, req_i dropped -> gnt_o/addr_o stay stable. With SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16: timeout_o pulses after 16 HOLD cycles, then valid_o=0.
REQ-033 Scenario: enable_i=0 for 5 cycles during HOLD with ack_i=1 -> no change. The ack takes effect on the first enabled cycle.
REQ-034 Scenario: reset asserted mid-HOLD -> the next cycle shows all outputs 0 and busy_o=0, then normal arbitration restarts from group 0.
